// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: latches the fetch-stage prediction and checks it in decode.
// On a wrong prediction it flushes decode, redirects fetch and trains the predictor.
module branch_resolve_unit #(
    parameter int CNT_W       = 16,
    parameter int RECOVER_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stalld,
    input  logic             flush_ext,
    input  logic             isbranch_f,
    input  logic             pred_taken_f,
    input  logic             pred_hit_f,
    input  logic [31:0]      pred_target_f,
    input  logic [31:0]      pcf,
    input  logic             branchd,
    input  logic             pcsrcd,
    input  logic [31:0]      pcbranchd,
    input  logic [31:0]      pcplus4d,
    output logic             mispredict_d,
    output logic [31:0]      redirect_pc,
    output logic             flushd_req,
    output logic             upd_valid,
    output logic             upd_alloc,
    output logic             upd_taken,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_RECOVER = 1'b1
    } state_t;

    localparam logic [1:0]       REC_LOAD = 2'(RECOVER_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_rec_cnt;
    logic [1:0]       w_rec_cnt_nxt;

    logic             r_meta_valid;
    logic             r_meta_taken;
    logic             r_meta_hit;
    logic [31:0]      r_meta_target;
    logic [31:0]      r_meta_pc;

    logic             w_resolve;
    logic             w_eff_hit;
    logic             w_eff_taken;
    logic             w_mispredict;
    logic [31:0]      w_redirect;

    logic             r_upd_valid;
    logic             r_upd_alloc;
    logic             r_upd_taken;
    logic [31:0]      r_upd_pc;
    logic [31:0]      r_upd_target;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    // FSM state register and recovery down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rec_cnt <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_rec_cnt <= w_rec_cnt_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_rec_cnt_nxt = r_rec_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_mispredict) begin
                    w_state_nxt   = S_RECOVER;
                    w_rec_cnt_nxt = REC_LOAD;
                end else begin
                    w_state_nxt   = S_IDLE;
                    w_rec_cnt_nxt = 2'd0;
                end
            end
            S_RECOVER: begin
                if (r_rec_cnt == 2'd0) begin
                    w_state_nxt   = S_IDLE;
                    w_rec_cnt_nxt = 2'd0;
                end else begin
                    w_state_nxt   = S_RECOVER;
                    w_rec_cnt_nxt = r_rec_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_rec_cnt_nxt = 2'd0;
            end
        endcase
    end

    // FSM outputs: resolve qualification, mispredict detection and redirect target
    always_comb begin
        w_resolve    = (r_state == S_IDLE) && !stalld && branchd;
        // A branch not seen at fetch behaves as a not-taken predictor miss
        w_eff_hit    = r_meta_valid && r_meta_hit;
        w_eff_taken  = w_eff_hit && r_meta_taken;
        w_mispredict = 1'b0;
        w_redirect   = 32'd0;
        if (w_resolve) begin
            if (w_eff_taken && !pcsrcd) begin
                w_mispredict = 1'b1;
                w_redirect   = pcplus4d;
            end else if (pcsrcd && (!w_eff_taken || (r_meta_target != pcbranchd))) begin
                w_mispredict = 1'b1;
                w_redirect   = pcbranchd;
            end else begin
                w_mispredict = 1'b0;
                w_redirect   = 32'd0;
            end
        end else begin
            w_mispredict = 1'b0;
            w_redirect   = 32'd0;
        end
    end

    // F->D prediction metadata: flushes beat stalls
    always_ff @(posedge clk) begin
        if (reset || flush_ext || w_mispredict) begin
            r_meta_valid  <= 1'b0;
            r_meta_taken  <= 1'b0;
            r_meta_hit    <= 1'b0;
            r_meta_target <= 32'd0;
            r_meta_pc     <= 32'd0;
        end else if (!stalld) begin
            r_meta_valid  <= isbranch_f;
            r_meta_taken  <= pred_taken_f;
            r_meta_hit    <= pred_hit_f;
            r_meta_target <= pred_target_f;
            r_meta_pc     <= pcf;
        end else begin
            r_meta_valid  <= r_meta_valid;
            r_meta_taken  <= r_meta_taken;
            r_meta_hit    <= r_meta_hit;
            r_meta_target <= r_meta_target;
            r_meta_pc     <= r_meta_pc;
        end
    end

    // Predictor update command, one strobe per resolved branch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_upd_valid  <= 1'b0;
            r_upd_alloc  <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_upd_pc     <= 32'd0;
            r_upd_target <= 32'd0;
        end else if (w_resolve) begin
            r_upd_valid  <= 1'b1;
            r_upd_alloc  <= !w_eff_hit;
            r_upd_taken  <= pcsrcd;
            r_upd_pc     <= r_meta_valid ? r_meta_pc : (pcplus4d - 32'd4);
            r_upd_target <= pcbranchd;
        end else begin
            r_upd_valid  <= 1'b0;
        end
    end

    // Saturating branch and mispredict statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt  <= {CNT_W{1'b0}};
            r_mispred_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_resolve && (r_branch_cnt != CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_mispredict && (r_mispred_cnt != CNT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
            end
        end
    end

    assign mispredict_d = w_mispredict;
    assign redirect_pc  = w_redirect;
    assign flushd_req   = w_mispredict;
    assign upd_valid    = r_upd_valid;
    assign upd_alloc    = r_upd_alloc;
    assign upd_taken    = r_upd_taken;
    assign upd_pc       = r_upd_pc;
    assign upd_target   = r_upd_target;
    assign branch_cnt   = r_branch_cnt;
    assign mispred_cnt  = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic compared against a behavioural model of the resolve rules.
module tb_branch_resolve_unit;

    localparam int TB_CNT_W = 4;
    localparam int TB_REC   = 2;
    localparam int CMAX     = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stalld, flush_ext, isbranch_f, pred_taken_f, pred_hit_f;
    logic [31:0] pred_target_f, pcf;
    logic        branchd, pcsrcd;
    logic [31:0] pcbranchd, pcplus4d;
    logic        mispredict_d, flushd_req, upd_valid, upd_alloc, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [TB_CNT_W-1:0] branch_cnt, mispred_cnt;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(.CNT_W(TB_CNT_W), .RECOVER_CYC(TB_REC)) dut (
        .clk(clk), .reset(reset), .stalld(stalld), .flush_ext(flush_ext),
        .isbranch_f(isbranch_f), .pred_taken_f(pred_taken_f), .pred_hit_f(pred_hit_f),
        .pred_target_f(pred_target_f), .pcf(pcf), .branchd(branchd), .pcsrcd(pcsrcd),
        .pcbranchd(pcbranchd), .pcplus4d(pcplus4d), .mispredict_d(mispredict_d),
        .redirect_pc(redirect_pc), .flushd_req(flushd_req), .upd_valid(upd_valid),
        .upd_alloc(upd_alloc), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .upd_target(upd_target), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // Reference model: pending fetch prediction, cycles of recovery left, counters
    logic        m_valid = 1'b0, m_taken = 1'b0, m_hit = 1'b0;
    logic [31:0] m_target = 32'd0, m_pc = 32'd0;
    int          m_rec_left = 0, m_bcnt = 0, m_mcnt = 0;
    logic        e_uv = 1'b0, e_ua = 1'b0, e_ut = 1'b0;
    logic [31:0] e_up = 32'd0, e_utg = 32'd0;
    logic        m_pred, m_resolve, m_mis;
    logic [31:0] m_redir;

    // Model combinational view of the current decode slot
    always_comb begin
        m_pred    = m_valid && m_taken && m_hit;
        m_resolve = (m_rec_left == 0) && !stalld && branchd;
        m_mis     = m_resolve && ((m_pred != pcsrcd) || (m_pred && (m_target != pcbranchd)));
        m_redir   = m_mis ? (pcsrcd ? pcbranchd : pcplus4d) : 32'd0;
    end

    // Model state advance
    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0; m_taken <= 1'b0; m_hit <= 1'b0;
            m_target <= 32'd0; m_pc <= 32'd0;
            m_rec_left <= 0; m_bcnt <= 0; m_mcnt <= 0;
            e_uv <= 1'b0; e_ua <= 1'b0; e_ut <= 1'b0; e_up <= 32'd0; e_utg <= 32'd0;
        end else begin
            if (m_mis) m_rec_left <= TB_REC;
            else if (m_rec_left > 0) m_rec_left <= m_rec_left - 1;
            if (flush_ext || m_mis) begin
                m_valid <= 1'b0; m_taken <= 1'b0; m_hit <= 1'b0;
                m_target <= 32'd0; m_pc <= 32'd0;
            end else if (!stalld) begin
                m_valid <= isbranch_f; m_taken <= pred_taken_f; m_hit <= pred_hit_f;
                m_target <= pred_target_f; m_pc <= pcf;
            end
            e_uv <= m_resolve;
            if (m_resolve) begin
                e_ua  <= !(m_valid && m_hit);
                e_ut  <= pcsrcd;
                e_up  <= m_valid ? m_pc : pcplus4d - 32'd4;
                e_utg <= pcbranchd;
                m_bcnt <= (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
                if (m_mis) m_mcnt <= (m_mcnt < CMAX) ? m_mcnt + 1 : CMAX;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fetch(input logic tk, input logic ht, input logic [31:0] tgt, input logic [31:0] pc);
        isbranch_f = 1'b1; pred_taken_f = tk; pred_hit_f = ht; pred_target_f = tgt; pcf = pc;
        branchd = 1'b0;
        step();
        isbranch_f = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_checks++; if (upd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_upd_valid got %0h want 0", upd_valid); end
        n_checks++; if ({upd_alloc, upd_taken, upd_pc, upd_target} !== 66'd0) begin n_errors++; $display("FAIL rst_upd_fields got %0h want 0", {upd_alloc, upd_taken, upd_pc, upd_target}); end
        n_checks++; if ({branch_cnt, mispred_cnt} !== 8'd0) begin n_errors++; $display("FAIL rst_counters got %0h want 0", {branch_cnt, mispred_cnt}); end
        n_checks++; if ({mispredict_d, flushd_req, redirect_pc} !== 34'd0) begin n_errors++; $display("FAIL rst_comb got %0h want 0", {mispredict_d, flushd_req, redirect_pc}); end
        reset = 1'b0;
    endtask

    task automatic test_hit_taken_correct();
        load_fetch(1'b1, 1'b1, 32'h80, 32'h40);
        branchd = 1'b1; pcsrcd = 1'b1; pcbranchd = 32'h80; pcplus4d = 32'h44;
        #1;
        n_checks++; if (mispredict_d !== 1'b0) begin n_errors++; $display("FAIL ht_mispredict got %0h want 0", mispredict_d); end
        n_checks++; if (redirect_pc !== 32'd0) begin n_errors++; $display("FAIL ht_redirect got %0h want 0", redirect_pc); end
        step();
        branchd = 1'b0;
        n_checks++; if ({upd_valid, upd_alloc, upd_taken} !== 3'b101) begin n_errors++; $display("FAIL ht_upd_flags got %b want 101", {upd_valid, upd_alloc, upd_taken}); end
        n_checks++; if (upd_pc !== 32'h40) begin n_errors++; $display("FAIL ht_upd_pc got %0h want 40", upd_pc); end
        n_checks++; if (upd_target !== 32'h80) begin n_errors++; $display("FAIL ht_upd_target got %0h want 80", upd_target); end
        n_checks++; if ({branch_cnt, mispred_cnt} !== {4'd1, 4'd0}) begin n_errors++; $display("FAIL ht_counts got %0h want 10", {branch_cnt, mispred_cnt}); end
        step();
        n_checks++; if ({upd_valid, upd_pc} !== {1'b0, 32'h40}) begin n_errors++; $display("FAIL ht_upd_hold got %0h want 40", {upd_valid, upd_pc}); end
    endtask

    task automatic test_mispredict_not_taken();
        load_fetch(1'b1, 1'b1, 32'h80, 32'h40);
        branchd = 1'b1; pcsrcd = 1'b0; pcbranchd = 32'h80; pcplus4d = 32'h44;
        #1;
        n_checks++; if ({mispredict_d, flushd_req} !== 2'b11) begin n_errors++; $display("FAIL nt_mispredict got %b want 11", {mispredict_d, flushd_req}); end
        n_checks++; if (redirect_pc !== 32'h44) begin n_errors++; $display("FAIL nt_redirect got %0h want 44", redirect_pc); end
        step();
        // Keep a would-be mispredicting branch in decode through recovery
        pcsrcd = 1'b1;
        for (int i = 0; i < TB_REC; i++) begin
            #1;
            n_checks++; if (mispredict_d !== 1'b0) begin n_errors++; $display("FAIL nt_recover_squash[%0d] got %0h want 0", i, mispredict_d); end
            step();
        end
        branchd = 1'b0;
        n_checks++; if ({branch_cnt, mispred_cnt} !== {4'd2, 4'd1}) begin n_errors++; $display("FAIL nt_counts got %0h want 21", {branch_cnt, mispred_cnt}); end
        n_checks++; if (upd_valid !== 1'b0) begin n_errors++; $display("FAIL nt_upd_after_recover got %0h want 0", upd_valid); end
    endtask

    task automatic test_miss_alloc();
        load_fetch(1'b1, 1'b0, 32'h300, 32'h200);
        branchd = 1'b1; pcsrcd = 1'b1; pcbranchd = 32'h100; pcplus4d = 32'h204;
        #1;
        n_checks++; if ({mispredict_d, redirect_pc} !== {1'b1, 32'h100}) begin n_errors++; $display("FAIL miss_redirect got %0h want 100000100", {mispredict_d, redirect_pc}); end
        step();
        branchd = 1'b0;
        n_checks++; if ({upd_valid, upd_alloc, upd_taken} !== 3'b111) begin n_errors++; $display("FAIL miss_upd_flags got %b want 111", {upd_valid, upd_alloc, upd_taken}); end
        n_checks++; if ({upd_pc, upd_target} !== {32'h200, 32'h100}) begin n_errors++; $display("FAIL miss_upd_addr got %0h want 20000000100", {upd_pc, upd_target}); end
        step(); step();
    endtask

    task automatic test_wrong_target();
        load_fetch(1'b1, 1'b1, 32'h80, 32'h40);
        branchd = 1'b1; pcsrcd = 1'b1; pcbranchd = 32'h90; pcplus4d = 32'h44;
        #1;
        n_checks++; if ({mispredict_d, redirect_pc} !== {1'b1, 32'h90}) begin n_errors++; $display("FAIL tgt_redirect got %0h want 100000090", {mispredict_d, redirect_pc}); end
        step();
        branchd = 1'b0;
        n_checks++; if ({upd_alloc, upd_target} !== {1'b0, 32'h90}) begin n_errors++; $display("FAIL tgt_upd got %0h want 90", {upd_alloc, upd_target}); end
        step(); step();
        n_checks++; if ({branch_cnt, mispred_cnt} !== {4'd4, 4'd3}) begin n_errors++; $display("FAIL tgt_counts got %0h want 43", {branch_cnt, mispred_cnt}); end
    endtask

    task automatic test_stall();
        load_fetch(1'b1, 1'b1, 32'h80, 32'h40);
        stalld = 1'b1; branchd = 1'b1; pcsrcd = 1'b1; pcbranchd = 32'h80; pcplus4d = 32'h44;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (upd_valid !== 1'b0) begin n_errors++; $display("FAIL stall_no_upd[%0d] got %0h want 0", i, upd_valid); end
        end
        stalld = 1'b0;
        #1;
        n_checks++; if (mispredict_d !== 1'b0) begin n_errors++; $display("FAIL stall_release_mis got %0h want 0", mispredict_d); end
        step();
        branchd = 1'b0;
        n_checks++; if ({upd_valid, upd_pc} !== {1'b1, 32'h40}) begin n_errors++; $display("FAIL stall_upd got %0h want 100000040", {upd_valid, upd_pc}); end
        step();
        n_checks++; if (upd_valid !== 1'b0) begin n_errors++; $display("FAIL stall_single_pulse got %0h want 0", upd_valid); end
        n_checks++; if ({branch_cnt, mispred_cnt} !== {4'd5, 4'd3}) begin n_errors++; $display("FAIL stall_counts got %0h want 53", {branch_cnt, mispred_cnt}); end
    endtask

    task automatic test_flush_with_resolve();
        load_fetch(1'b1, 1'b1, 32'h80, 32'h40);
        // The next fetch prediction would be correct, but the flush must drop it
        isbranch_f = 1'b1; pred_taken_f = 1'b1; pred_hit_f = 1'b1; pred_target_f = 32'h80; pcf = 32'h48;
        branchd = 1'b1; pcsrcd = 1'b1; pcbranchd = 32'h80; pcplus4d = 32'h44; flush_ext = 1'b1;
        step();
        flush_ext = 1'b0; isbranch_f = 1'b0;
        #1;
        n_checks++; if ({upd_valid, upd_pc} !== {1'b1, 32'h40}) begin n_errors++; $display("FAIL flush_resolve_upd got %0h want 100000040", {upd_valid, upd_pc}); end
        n_checks++; if ({mispredict_d, redirect_pc} !== {1'b1, 32'h80}) begin n_errors++; $display("FAIL flush_cleared_meta got %0h want 100000080", {mispredict_d, redirect_pc}); end
        step();
        branchd = 1'b0;
        step(); step();
        n_checks++; if ({branch_cnt, mispred_cnt} !== {4'd7, 4'd4}) begin n_errors++; $display("FAIL flush_counts got %0h want 74", {branch_cnt, mispred_cnt}); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            branchd = 1'b1; pcsrcd = 1'b1; pcbranchd = 32'h100; pcplus4d = 32'h104;
            step();
            branchd = 1'b0;
            step(); step();
        end
        n_checks++; if (mispred_cnt !== 4'd15) begin n_errors++; $display("FAIL sat_mispred got %0d want 15", mispred_cnt); end
        n_checks++; if (branch_cnt !== 4'd15) begin n_errors++; $display("FAIL sat_branch got %0d want 15", branch_cnt); end
    endtask

    task automatic test_reset_in_recover();
        branchd = 1'b1; pcsrcd = 1'b1; pcbranchd = 32'h100; pcplus4d = 32'h104;
        step();
        branchd = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if ({upd_valid, branch_cnt, mispred_cnt} !== 9'd0) begin n_errors++; $display("FAIL rr_cleared got %0h want 0", {upd_valid, branch_cnt, mispred_cnt}); end
        branchd = 1'b1;
        #1;
        n_checks++; if ({mispredict_d, redirect_pc} !== {1'b1, 32'h100}) begin n_errors++; $display("FAIL rr_idle_resolve got %0h want 100000100", {mispredict_d, redirect_pc}); end
        step();
        branchd = 1'b0;
        step(); step();
    endtask

    task automatic test_random();
        int shown = 0;
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 99) < 2);
            stalld        = ($urandom_range(0, 3) == 0);
            flush_ext     = ($urandom_range(0, 9) == 0);
            isbranch_f    = $urandom_range(0, 1) == 1;
            pred_taken_f  = $urandom_range(0, 1) == 1;
            pred_hit_f    = $urandom_range(0, 1) == 1;
            pred_target_f = 32'($urandom_range(0, 3)) << 4;
            pcf           = $urandom & 32'hFFFF_FFFC;
            branchd       = $urandom_range(0, 1) == 1;
            pcsrcd        = $urandom_range(0, 1) == 1;
            pcbranchd     = 32'($urandom_range(0, 3)) << 4;
            pcplus4d      = $urandom & 32'hFFFF_FFFC;
            #1;
            n_checks++;
            if ({mispredict_d, flushd_req, redirect_pc} !== {m_mis, m_mis, m_redir}) begin
                n_errors++;
                if (shown < 10) $display("FAIL rnd_comb[%0d] got %0h want %0h", i, {mispredict_d, flushd_req, redirect_pc}, {m_mis, m_mis, m_redir});
                shown++;
            end
            step();
            n_checks++;
            if ({upd_valid, upd_alloc, upd_taken, upd_pc, upd_target, branch_cnt, mispred_cnt} !==
                {e_uv, e_ua, e_ut, e_up, e_utg, 4'(m_bcnt), 4'(m_mcnt)}) begin
                n_errors++;
                if (shown < 10) $display("FAIL rnd_reg[%0d] got %0h want %0h", i,
                    {upd_valid, upd_alloc, upd_taken, upd_pc, upd_target, branch_cnt, mispred_cnt},
                    {e_uv, e_ua, e_ut, e_up, e_utg, 4'(m_bcnt), 4'(m_mcnt)});
                shown++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stalld = 1'b0; flush_ext = 1'b0; isbranch_f = 1'b0;
        pred_taken_f = 1'b0; pred_hit_f = 1'b0; pred_target_f = 32'd0; pcf = 32'd0;
        branchd = 1'b0; pcsrcd = 1'b0; pcbranchd = 32'd0; pcplus4d = 32'd0;
        #1;
        test_reset();
        test_hit_taken_correct();
        test_mispredict_not_taken();
        test_miss_alloc();
        test_wrong_target();
        test_stall();
        test_flush_with_resolve();
        test_saturation();
        test_reset_in_recover();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
